// File: rtl/except_pkg.sv
// Shared definitions for the exception sequencer: cause codes, CP0 register
// addresses and the sequencer state encoding.
package except_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_t;

endpackage

// File: rtl/except_prio.sv
// Fixed-priority cause selector: picks one exception code from the flags of a
// valid instruction; hit is set whenever a cause is selected.
module except_prio
  import except_pkg::*;
(
  input  logic        inst_valid,
  input  logic        irq,
  input  logic        exc_syscall,
  input  logic        exc_inv,
  input  logic        exc_trap,
  input  logic        exc_ov,
  input  logic        exc_eret,
  output logic [31:0] code,
  output logic        hit
);

  always_comb begin
    code = EXC_NONE;
    if (inst_valid) begin
      if (irq)              code = EXC_INT;
      else if (exc_syscall) code = EXC_SYSCALL;
      else if (exc_inv)     code = EXC_INV;
      else if (exc_trap)    code = EXC_TRAP;
      else if (exc_ov)      code = EXC_OV;
      else if (exc_eret)    code = EXC_ERET;
    end
  end

  assign hit = (code != EXC_NONE);

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: select, flush, redirect.
// Optional macro EXCEPT_TIMER_INT_EN adds timer_int_i, ORed into IP7.
module except_ctrl
  import except_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic        exc_syscall_i,
  input  logic        exc_inv_i,
  input  logic        exc_trap_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic [5:0]  int_i,
`ifdef EXCEPT_TIMER_INT_EN
  input  logic        timer_int_i,
`endif
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        busy_o
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] target_reg, target_next;
  logic [31:0] excepttype_next, inst_addr_next, new_pc_next;
  logic        delayslot_next, flush_next, stall_next, new_pc_valid_next;

  // An MTC0 still in WB must be visible to this cycle's decision.
  logic [31:0] status_eff, epc_eff;
  logic [1:0]  cause_ip;
  logic [5:0]  hw_ip;
  logic        irq;
  logic [31:0] code;
  logic        hit;

  assign status_eff = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign epc_eff    = (cp0_we_i && cp0_waddr_i == CP0_EPC)    ? cp0_wdata_i : cp0_epc_i;
  assign cause_ip   = (cp0_we_i && cp0_waddr_i == CP0_CAUSE)  ? cp0_wdata_i[9:8]
                                                              : cp0_cause_i[9:8];
`ifdef EXCEPT_TIMER_INT_EN
  assign hw_ip = {int_i[5] | timer_int_i, int_i[4:0]};
`else
  assign hw_ip = int_i;
`endif

  assign irq = status_eff[0] & ~status_eff[1] & (|({hw_ip, cause_ip} & status_eff[15:8]));

  logic unused_bits;
  assign unused_bits = ^{cp0_cause_i[31:10], cp0_cause_i[7:0],
                         status_eff[31:16], status_eff[7:2]};

  except_prio u_prio (
    .inst_valid  (inst_valid_i),
    .irq         (irq),
    .exc_syscall (exc_syscall_i),
    .exc_inv     (exc_inv_i),
    .exc_trap    (exc_trap_i),
    .exc_ov      (exc_ov_i),
    .exc_eret    (exc_eret_i),
    .code        (code),
    .hit         (hit)
  );

  // Outputs are registered from the decision made in the current state.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    target_next       = target_reg;
    excepttype_next   = EXC_NONE;
    inst_addr_next    = 32'h0;
    delayslot_next    = 1'b0;
    flush_next        = 1'b0;
    stall_next        = 1'b0;
    new_pc_next       = new_pc_o;
    new_pc_valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hit) begin
          excepttype_next = code;
          inst_addr_next  = pc_i;
          delayslot_next  = in_delayslot_i;
          flush_next      = 1'b1;
          stall_next      = 1'b1;
          target_next     = (code == EXC_ERET) ? epc_eff : EXC_VECTOR;
          cnt_next        = CNT_LOAD;
          state_next      = (FLUSH_CYCLES == 1) ? ST_REDIRECT : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_next = 1'b1;
        stall_next = 1'b1;
        cnt_next   = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        new_pc_next       = target_reg;
        new_pc_valid_next = 1'b1;
        stall_next        = 1'b1;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg           <= ST_IDLE;
      cnt_reg             <= 4'd0;
      target_reg          <= 32'h0;
      excepttype_o        <= EXC_NONE;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      stall_o             <= 1'b0;
      new_pc_o            <= 32'h0;
      new_pc_valid_o      <= 1'b0;
    end else begin
      state_reg           <= state_next;
      cnt_reg             <= cnt_next;
      target_reg          <= target_next;
      excepttype_o        <= excepttype_next;
      current_inst_addr_o <= inst_addr_next;
      is_in_delayslot_o   <= delayslot_next;
      flush_o             <= flush_next;
      stall_o             <= stall_next;
      new_pc_o            <= new_pc_next;
      new_pc_valid_o      <= new_pc_valid_next;
    end
  end

  assign busy_o = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_except_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk, resetn;
  logic        inst_valid_i, in_delayslot_i;
  logic [31:0] pc_i;
  logic        exc_syscall_i, exc_inv_i, exc_trap_i, exc_ov_i, exc_eret_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, stall_o, new_pc_valid_o, busy_o;

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .inst_valid_i(inst_valid_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
    .exc_syscall_i(exc_syscall_i), .exc_inv_i(exc_inv_i), .exc_trap_i(exc_trap_i),
    .exc_ov_i(exc_ov_i), .exc_eret_i(exc_eret_i), .int_i(int_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .stall_o(stall_o),
    .new_pc_o(new_pc_o), .new_pc_valid_o(new_pc_valid_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a detection pre-plans every output cycle of the sequence.
  typedef struct {
    logic [31:0] exc;
    logic [31:0] addr;
    logic        ds;
    logic        fl;
    logic        st;
    logic        npv;
    logic [31:0] npc;
  } exp_t;

  exp_t        plan[$];
  exp_t        cur;
  logic [31:0] m_newpc;
  logic        m_busy;

  function automatic exp_t zexp();
    exp_t e;
    e.exc = 0; e.addr = 0; e.ds = 0; e.fl = 0; e.st = 0; e.npv = 0; e.npc = 0;
    return e;
  endfunction

  function automatic logic [31:0] ref_code();
    logic [31:0] status;
    logic [1:0]  sw_ip;
    logic        irq;
    status = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : cp0_status_i;
    sw_ip  = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
    irq = 1'b0;
    for (int b = 0; b < 8; b++) begin
      logic pend;
      pend = (b < 2) ? sw_ip[b] : int_i[b-2];
      if (pend && status[8+b]) irq = 1'b1;
    end
    irq = irq && status[0] && !status[1];
    if (!inst_valid_i) return 32'h0;
    if (irq)           return 32'h1;
    if (exc_syscall_i) return 32'h8;
    if (exc_inv_i)     return 32'ha;
    if (exc_trap_i)    return 32'hd;
    if (exc_ov_i)      return 32'hc;
    if (exc_eret_i)    return 32'he;
    return 32'h0;
  endfunction

  initial begin
    cur = zexp();
    m_newpc = 32'h0;
    m_busy = 1'b0;
  end

  always @(posedge clk) begin
    logic [31:0] code;
    exp_t e;
    if (!resetn) begin
      plan.delete();
      cur = zexp();
      m_newpc = 32'h0;
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else begin
      cur = zexp();
      code = ref_code();
      if (code != 32'h0) begin
        cur.exc = code; cur.addr = pc_i; cur.ds = in_delayslot_i; cur.fl = 1; cur.st = 1;
        for (int i = 1; i < FC; i++) begin
          e = zexp(); e.fl = 1; e.st = 1;
          plan.push_back(e);
        end
        e = zexp(); e.st = 1; e.npv = 1;
        if (code == 32'he)
          e.npc = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : cp0_epc_i;
        else
          e.npc = VEC;
        plan.push_back(e);
      end
    end
    if (cur.npv) m_newpc = cur.npc;
    m_busy = (plan.size() > 0);
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_excepttype", excepttype_o, cur.exc);
      chk("m_inst_addr", current_inst_addr_o, cur.addr);
      chk("m_delayslot", {31'b0, is_in_delayslot_o}, {31'b0, cur.ds});
      chk("m_flush", {31'b0, flush_o}, {31'b0, cur.fl});
      chk("m_stall", {31'b0, stall_o}, {31'b0, cur.st});
      chk("m_new_pc_valid", {31'b0, new_pc_valid_o}, {31'b0, cur.npv});
      chk("m_new_pc", new_pc_o, m_newpc);
      chk("m_busy", {31'b0, busy_o}, {31'b0, m_busy});
    end
  end

  task automatic clear_inputs();
    inst_valid_i = 0; pc_i = 0; in_delayslot_i = 0;
    exc_syscall_i = 0; exc_inv_i = 0; exc_trap_i = 0; exc_ov_i = 0; exc_eret_i = 0;
    int_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses;

  initial begin
    clear_inputs();
    resetn = 0;
    cyc(2);
    check_en = 1;
    chk("rst_excepttype", excepttype_o, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    resetn = 1;
    cyc(1);

    // Syscall: code on cycle 1, flush cycles 1..2, redirect to vector on cycle 3
    inst_valid_i = 1; pc_i = 32'h1000; exc_syscall_i = 1;
    cyc(1); clear_inputs();
    chk("sys_code", excepttype_o, 32'h8);
    chk("sys_addr", current_inst_addr_o, 32'h1000);
    chk("sys_flush1", {31'b0, flush_o}, 32'h1);
    cyc(1);
    chk("sys_flush2", {31'b0, flush_o}, 32'h1);
    chk("sys_code_clr", excepttype_o, 32'h0);
    cyc(1);
    chk("sys_npv", {31'b0, new_pc_valid_o}, 32'h1);
    chk("sys_new_pc", new_pc_o, 32'h20);
    chk("sys_flush_off", {31'b0, flush_o}, 32'h0);
    cyc(1);
    chk("sys_npv_off", {31'b0, new_pc_valid_o}, 32'h0);
    chk("sys_new_pc_hold", new_pc_o, 32'h20);

    // Interrupt beats overflow
    inst_valid_i = 1; cp0_status_i = 32'h0000_0401; int_i = 6'b000001; exc_ov_i = 1;
    cyc(1); clear_inputs();
    chk("irq_code", excepttype_o, 32'h1);
    cyc(3);

    // ERET picks up the in-flight EPC write
    inst_valid_i = 1; exc_eret_i = 1; cp0_epc_i = 32'h100;
    cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h200;
    cyc(1); clear_inputs();
    chk("eret_code", excepttype_o, 32'he);
    cyc(2);
    chk("eret_npv", {31'b0, new_pc_valid_o}, 32'h1);
    chk("eret_new_pc", new_pc_o, 32'h200);
    cyc(1);

    // EXL set masks all interrupts
    inst_valid_i = 1; cp0_status_i = 32'h0000_ff03; int_i = 6'h3f;
    cyc(1); clear_inputs();
    chk("exl_busy", {31'b0, busy_o}, 32'h0);
    chk("exl_code", excepttype_o, 32'h0);
    cyc(1);

    // Trap, then reset during flush: no redirect afterwards
    inst_valid_i = 1; exc_trap_i = 1;
    cyc(1); clear_inputs();
    chk("trap_code", excepttype_o, 32'hd);
    resetn = 0;
    cyc(1);
    chk("trap_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("trap_rst_code", excepttype_o, 32'h0);
    resetn = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (new_pc_valid_o) pulses++;
    end
    chk("trap_rst_pulses", pulses, 32'd0);

    // Syscall held through the busy window yields a single redirect
    inst_valid_i = 1; exc_syscall_i = 1; pc_i = 32'h2000;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (new_pc_valid_o) begin
        pulses++;
        clear_inputs();
      end
    end
    clear_inputs();
    chk("busy_pulses", pulses, 32'd1);
    cyc(2);

    // Randomized traffic, occasional resets and CP0 bypass writes
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      inst_valid_i   = ($urandom_range(0, 3) != 0);
      pc_i           = {$urandom_range(0, 32'hffff), 2'b00};
      in_delayslot_i = $urandom_range(0, 1) == 1;
      exc_syscall_i  = $urandom_range(0, 9) == 0;
      exc_inv_i      = $urandom_range(0, 9) == 0;
      exc_trap_i     = $urandom_range(0, 9) == 0;
      exc_ov_i       = $urandom_range(0, 9) == 0;
      exc_eret_i     = $urandom_range(0, 9) == 0;
      int_i          = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      cp0_status_i   = {16'h0, 16'($urandom)};
      cp0_cause_i    = $urandom;
      cp0_epc_i      = $urandom;
      cp0_we_i       = $urandom_range(0, 3) == 0;
      cp0_waddr_i    = 5'($urandom_range(11, 15));
      cp0_wdata_i    = $urandom;
      resetn         = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    clear_inputs();
    resetn = 1;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
